bitstream_classifier: RTL and testbench

BITSTREAM_CLASSIFIER -- requirements
Module: bitstream_classifier

---
 rtl/bitstream_classifier_if.sv | 16 +
 rtl/bitstream_classifier.sv | 72 +++++++
 tb/tb_bitstream_classifier.sv | 117 +++++++++++
 3 files changed

// File: rtl/bitstream_classifier_if.sv
// bitstream_classifier_if: classifier bus; master drives compute/bits_in, slave returns count_out/class_out/valid/busy/overrun
interface bitstream_classifier_if #(
  parameter int N_CLASSES = 3,
  parameter int CNT_W = 10,
  parameter int CLS_W = N_CLASSES > 1 ? $clog2(N_CLASSES) : 1
);
  logic compute;
  logic [N_CLASSES-1:0] bits_in;
  logic [N_CLASSES*CNT_W-1:0] count_out;
  logic [CLS_W-1:0] class_out;
  logic valid;
  logic busy;
  logic overrun;
  modport master(output compute, bits_in, input count_out, class_out, valid, busy, overrun);
  modport slave(input compute, bits_in, output count_out, class_out, valid, busy, overrun);
endinterface

// File: rtl/bitstream_classifier.sv
// bitstream_classifier: counts ones per class over a compute window and reports argmax; ports clk, rst, bus (slave: compute/bits_in in, count_out/class_out/valid/busy/overrun out)
module bitstream_classifier #(
  parameter int N_CLASSES = 3,
  parameter int BITSTREAM_LENGTH = 256,
  parameter int CNT_W = 10
) (
  input logic clk,
  input logic rst,
  bitstream_classifier_if.slave bus
);
  localparam int CLS_W = N_CLASSES > 1 ? $clog2(N_CLASSES) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state_q;
  logic [N_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_ld, count_q;
  logic [CNT_W-1:0] win_q, win_d, best_cnt;
  logic [CLS_W-1:0] best_idx, class_q;
  logic valid_q, busy_q, overrun_q;
  always_comb begin
    win_d = win_q + CNT_W'(win_q != '1);
    best_idx = '0;
    best_cnt = cnt_q[0];
    for (int k = 0; k < N_CLASSES; k++) begin
      cnt_d[k] = cnt_q[k] + CNT_W'(bus.bits_in[k] && cnt_q[k] != '1);
      cnt_ld[k] = CNT_W'(bus.bits_in[k]);
      if (cnt_q[k] > best_cnt) begin
        best_cnt = cnt_q[k];
        best_idx = CLS_W'(k);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      count_q <= '0;
      win_q <= '0;
      class_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      if (state_q == ACCUM) begin
        if (bus.compute) begin
          cnt_q <= cnt_d;
          win_q <= win_d;
          overrun_q <= overrun_q | (win_q >= CNT_W'(BITSTREAM_LENGTH) && win_q != '1);
          busy_q <= 1'b1;
        end else begin
          state_q <= DONE;
          count_q <= cnt_q;
          class_q <= best_idx;
          valid_q <= 1'b1;
        end
      end else if (bus.compute) begin
        state_q <= ACCUM;
        cnt_q <= cnt_ld;
        win_q <= CNT_W'(1);
        overrun_q <= 1'b0;
        busy_q <= 1'b1;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign bus.count_out = count_q;
  assign bus.class_out = class_q;
  assign bus.valid = valid_q;
  assign bus.busy = busy_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_bitstream_classifier.sv
// tb_bitstream_classifier: directed self-checking bench for bitstream_classifier
module tb_bitstream_classifier;
  localparam int W = 10;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_valid;
  int t_prev;
  bitstream_classifier_if #(.N_CLASSES(3), .CNT_W(W)) bus();
  bitstream_classifier #(.N_CLASSES(3), .BITSTREAM_LENGTH(256), .CNT_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int cnt_of(input int k);
    logic [3*W-1:0] v;
    v = bus.count_out;
    return int'(v[k*W +: W]);
  endfunction
  function automatic int expc(input int n, input int len);
    int m;
    m = n < len ? n : len;
    return m > 1023 ? 1023 : m;
  endfunction
  task automatic run_window(input string tag, input int len, input int n0, input int n1, input int n2,
                            input int exp_cls, input int exp_ovr);
    for (int c = 0; c < len; c++) begin
      bus.compute = 1'b1;
      bus.bits_in = {c < n2, c < n1, c < n0};
      step();
      if (c == 0) begin
        chk({tag, ".busy"}, int'(bus.busy), 1);
        chk({tag, ".valid_acc"}, int'(bus.valid), 0);
      end
      if (len > 256 && (c == 255 || c == 256)) chk({tag, ".ovr_edge"}, int'(bus.overrun), c == 256 ? 1 : 0);
    end
    bus.compute = 1'b0;
    bus.bits_in = '0;
    step();
    t_valid = cyc;
    chk({tag, ".valid"}, int'(bus.valid), 1);
    chk({tag, ".busy_done"}, int'(bus.busy), 0);
    chk({tag, ".c0"}, cnt_of(0), expc(n0, len));
    chk({tag, ".c1"}, cnt_of(1), expc(n1, len));
    chk({tag, ".c2"}, cnt_of(2), expc(n2, len));
    chk({tag, ".class"}, int'(bus.class_out), exp_cls);
    chk({tag, ".ovr"}, int'(bus.overrun), exp_ovr);
  endtask
  task automatic idle(input string tag);
    bus.compute = 1'b0;
    bus.bits_in = '0;
    step();
    chk({tag, ".valid_off"}, int'(bus.valid), 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.compute = 1'b0;
    bus.bits_in = '0;
    step();
    step();
    chk("rst.valid", int'(bus.valid), 0);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.ovr", int'(bus.overrun), 0);
    chk("rst.count", int'(bus.count_out == '0), 1);
    chk("rst.class", int'(bus.class_out), 0);
    rst = 1'b0;
    run_window("r030", 256, 256, 0, 0, 0, 0);
    idle("r030");
    chk("r030.hold", cnt_of(0), 256);
    run_window("r031", 256, 50, 200, 150, 1, 0);
    idle("r031");
    run_window("r032", 256, 128, 128, 10, 0, 0);
    idle("r032");
    run_window("r033a", 300, 300, 300, 300, 0, 1);
    idle("r033a");
    run_window("r033b", 1100, 1100, 1100, 1100, 0, 1);
    idle("r033b");
    run_window("r033c", 256, 5, 9, 9, 1, 0);
    idle("r033c");
    for (int c = 0; c < 100; c++) begin
      bus.compute = 1'b1;
      bus.bits_in = 3'b111;
      step();
    end
    rst = 1'b1;
    step();
    chk("r034.valid", int'(bus.valid), 0);
    chk("r034.busy", int'(bus.busy), 0);
    chk("r034.count", int'(bus.count_out == '0), 1);
    chk("r034.class", int'(bus.class_out), 0);
    rst = 1'b0;
    run_window("r034w", 256, 20, 40, 7, 1, 0);
    idle("r034w");
    run_window("r035a", 256, 256, 256, 256, 0, 0);
    t_prev = t_valid;
    run_window("r035b", 256, 10, 20, 30, 2, 0);
    chk("r035.gap", t_valid - t_prev, 257);
    idle("r035b");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
